// File: rtl/dft_sample_feeder.sv
// Sample feeder for DFT_singleBin: buffers valid/ready samples and issues them as spaced write strobes.
// Optional drop counter built when FEEDER_DROP_COUNT_EN is defined; otherwise o_drop_count is tied to 0.
module dft_sample_feeder #(
    parameter int unsigned WIDTH          = 16,
    parameter int unsigned FIFO_DEPTH     = 8,
    parameter int unsigned LOG_FIFO_DEPTH = 3,
    parameter int unsigned SAMPLE_GAP     = 16
) (
    input  logic                      i_sys_clk,
    input  logic                      i_reset,
    input  logic signed [WIDTH-1:0]   i_x,
    input  logic                      i_valid,
    output logic                      o_ready,
    input  logic        [WIDTH-1:0]   i_N,
    output logic signed [WIDTH-1:0]   o_x,
    output logic        [WIDTH-1:0]   o_n,
    output logic                      o_wr,
    output logic                      o_frame_end,
    output logic [LOG_FIFO_DEPTH:0]   o_fifo_count,
    output logic        [WIDTH-1:0]   o_drop_count
);

    localparam int unsigned CNT_W = LOG_FIFO_DEPTH + 1;
    localparam int unsigned GAP_W = (SAMPLE_GAP > 2) ? $clog2(SAMPLE_GAP) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    logic signed [WIDTH-1:0]    mem_q [FIFO_DEPTH];
    logic [LOG_FIFO_DEPTH-1:0]  wr_ptr_q;
    logic [LOG_FIFO_DEPTH-1:0]  rd_ptr_q;
    logic [CNT_W-1:0]           count_q;
    logic [CNT_W-1:0]           count_d;
    state_t                     state_q;
    logic [GAP_W-1:0]           gap_q;
    logic [WIDTH-1:0]           index_q;
    logic [WIDTH-1:0]           phase_q;
    logic                       push_c;
    logic                       pop_c;
    logic                       frame_end_c;
    logic [WIDTH-1:0]           neff_m1_c;

    // Full is decoded from the registered count, so a same-cycle pop never frees a slot early.
    assign o_ready      = (count_q < CNT_W'(FIFO_DEPTH));
    assign o_fifo_count = count_q;
    assign push_c       = i_valid && o_ready;
    assign pop_c        = (count_q != '0) &&
                          ((state_q == S_IDLE) || ((state_q == S_GAP) && (gap_q == '0)));

    // Effective frame length minus one; N of 0 or 1 marks every sample as a frame end.
    always_comb begin
        neff_m1_c   = '0;
        if (i_N > WIDTH'(1)) begin
            neff_m1_c = i_N - WIDTH'(1);
        end
        frame_end_c = (phase_q >= neff_m1_c);
    end

    always_comb begin
        count_d = count_q;
        case ({push_c, pop_c})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge i_sys_clk) begin
        if (push_c) begin
            mem_q[wr_ptr_q] <= i_x;
        end
    end

    always_ff @(posedge i_sys_clk) begin
        if (i_reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            count_q <= count_d;
            if (push_c) begin
                wr_ptr_q <= wr_ptr_q + LOG_FIFO_DEPTH'(1);
            end
            if (pop_c) begin
                rd_ptr_q <= rd_ptr_q + LOG_FIFO_DEPTH'(1);
            end
        end
    end

    // Issue FSM: outputs load on the edge entering ISSUE, so o_wr is high for exactly the ISSUE cycle.
    always_ff @(posedge i_sys_clk) begin
        if (i_reset) begin
            state_q     <= S_IDLE;
            gap_q       <= '0;
            index_q     <= '0;
            phase_q     <= '0;
            o_wr        <= 1'b0;
            o_x         <= '0;
            o_n         <= '0;
            o_frame_end <= 1'b0;
        end else begin
            o_wr <= 1'b0;
            if (pop_c) begin
                o_wr        <= 1'b1;
                o_x         <= mem_q[rd_ptr_q];
                o_n         <= index_q;
                o_frame_end <= frame_end_c;
                index_q     <= index_q + WIDTH'(1);
                phase_q     <= frame_end_c ? '0 : phase_q + WIDTH'(1);
            end
            case (state_q)
                S_IDLE: begin
                    if (pop_c) begin
                        state_q <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    state_q <= S_GAP;
                    gap_q   <= GAP_W'(SAMPLE_GAP - 2);
                end
                S_GAP: begin
                    if (gap_q != '0) begin
                        gap_q <= gap_q - GAP_W'(1);
                    end else if (pop_c) begin
                        state_q <= S_ISSUE;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

`ifdef FEEDER_DROP_COUNT_EN
    logic [WIDTH-1:0] drop_q;

    // Saturating count of samples offered while full.
    always_ff @(posedge i_sys_clk) begin
        if (i_reset) begin
            drop_q <= '0;
        end else if (i_valid && !o_ready && (drop_q != '1)) begin
            drop_q <= drop_q + WIDTH'(1);
        end
    end

    assign o_drop_count = drop_q;
`else
    assign o_drop_count = '0;
`endif

endmodule

// File: tb/tb_dft_sample_feeder.sv
// Scoreboard bench for dft_sample_feeder: a WIDTH=16 instance for the main behaviour and a
// WIDTH=4 instance for index wrap.
module tb_dft_sample_feeder;

    localparam int unsigned W    = 16;
    localparam int unsigned GAP  = 16;
    localparam int unsigned W4   = 4;
    localparam int unsigned GAP4 = 4;
`ifdef FEEDER_DROP_COUNT_EN
    localparam int DROP_ON = 1;
`else
    localparam int DROP_ON = 0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 rst;
    logic signed [W-1:0]  x;
    logic                 valid;
    logic        [W-1:0]  nlen;
    logic                 ready;
    logic signed [W-1:0]  ox;
    logic        [W-1:0]  on;
    logic                 wr;
    logic                 fe;
    logic        [3:0]    fc;
    logic        [W-1:0]  dc;

    logic signed [W4-1:0] x4;
    logic                 valid4;
    logic        [W4-1:0] nlen4;
    logic                 ready4;
    logic signed [W4-1:0] x4o;
    logic        [W4-1:0] n4o;
    logic                 wr4;
    logic                 fe4;
    logic        [3:0]    fc4;
    logic        [W4-1:0] dc4;

    dft_sample_feeder #(.WIDTH(W), .FIFO_DEPTH(8), .LOG_FIFO_DEPTH(3), .SAMPLE_GAP(GAP)) dut (
        .i_sys_clk(clk), .i_reset(rst), .i_x(x), .i_valid(valid), .o_ready(ready), .i_N(nlen),
        .o_x(ox), .o_n(on), .o_wr(wr), .o_frame_end(fe), .o_fifo_count(fc), .o_drop_count(dc)
    );

    dft_sample_feeder #(.WIDTH(W4), .FIFO_DEPTH(8), .LOG_FIFO_DEPTH(3), .SAMPLE_GAP(GAP4)) dut4 (
        .i_sys_clk(clk), .i_reset(rst), .i_x(x4), .i_valid(valid4), .o_ready(ready4), .i_N(nlen4),
        .o_x(x4o), .o_n(n4o), .o_wr(wr4), .o_frame_end(fe4), .o_fifo_count(fc4), .o_drop_count(dc4)
    );

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;

    logic signed [W-1:0]  exp_x_q [$];
    int                   wr_log  [$];
    bit                   fe_log  [$];
    logic        [W-1:0]  idx_m;
    logic        [W-1:0]  phase_m;
    logic        [W-1:0]  n_prev;

    logic signed [W4-1:0] exp4_q  [$];
    int                   log4    [$];
    int                   k4;

    task automatic check_eq(input string tag, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    always @(posedge clk) begin
        cyc    <= cyc + 1;
        n_prev <= nlen;
    end

    // Reference model for the main instance: FIFO order plus index/phase bookkeeping.
    always @(negedge clk) begin
        logic signed [W-1:0] ex;
        logic        [W-1:0] neff;
        bit                  fe_e;
        if (wr) begin
            check_eq("wr_expected", longint'(exp_x_q.size() > 0), 1);
            if (exp_x_q.size() > 0) begin
                ex   = exp_x_q.pop_front();
                neff = (n_prev <= 1) ? W'(1) : n_prev;
                fe_e = (phase_m >= neff - W'(1));
                check_eq("wr_x", ox, ex);
                check_eq("wr_n", on, idx_m);
                check_eq("wr_fe", fe, fe_e);
                idx_m   = idx_m + W'(1);
                phase_m = fe_e ? '0 : phase_m + W'(1);
            end
            wr_log.push_back(cyc);
            fe_log.push_back(fe);
        end
    end

    always @(negedge clk) begin
        logic signed [W4-1:0] e4;
        if (wr4) begin
            check_eq("w4_expected", longint'(exp4_q.size() > 0), 1);
            if (exp4_q.size() > 0) begin
                e4 = exp4_q.pop_front();
                check_eq("w4_x", x4o, e4);
                check_eq("w4_n", n4o, k4 % 16);
                check_eq("w4_fe", fe4, longint'((k4 % 3) == 2));
            end
            k4++;
            log4.push_back(cyc);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        valid = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic push(input logic signed [W-1:0] xv, input bit acc);
        valid = 1'b1;
        x     = xv;
        check_eq("ready", ready, acc);
        if (acc) exp_x_q.push_back(xv);
        tick();
    endtask

    task automatic wait_drain(input int budget);
        int i = 0;
        valid = 1'b0;
        while (exp_x_q.size() != 0 && i < budget) begin
            tick();
            i++;
        end
        check_eq("drain", exp_x_q.size(), 0);
    endtask

    task automatic do_reset();
        rst    = 1'b1;
        valid  = 1'b0;
        valid4 = 1'b0;
        tick();
        rst     = 1'b0;
        idx_m   = '0;
        phase_m = '0;
        k4      = 0;
        exp_x_q.delete();
        exp4_q.delete();
    endtask

    task automatic check_zero_outputs(input string tag);
        check_eq({tag, "_ox"}, ox, 0);
        check_eq({tag, "_on"}, on, 0);
        check_eq({tag, "_wr"}, wr, 0);
        check_eq({tag, "_fe"}, fe, 0);
        check_eq({tag, "_fc"}, fc, 0);
        check_eq({tag, "_dc"}, dc, 0);
        check_eq({tag, "_ready"}, ready, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        bit t4_exp [10];
        t4_exp = '{1, 1, 1, 1, 0, 0, 0, 1, 0, 1};
        rst = 1'b1; valid = 1'b0; x = '0; nlen = W'(2);
        valid4 = 1'b0; x4 = '0; nlen4 = W4'(3);
        idx_m = '0; phase_m = '0; k4 = 0;
        tick();
        do_reset();
        check_zero_outputs("reset");

        // Four back-to-back samples, N=2: strobes at t+2, t+18, t+34, t+50.
        wr_log.delete(); fe_log.delete();
        t0 = cyc;
        push(16'sd0, 1); push(-16'sd1, 1); push(16'sd0, 1); push(16'sd1, 1);
        wait_drain(100);
        check_eq("t1_count", wr_log.size(), 4);
        for (int k = 0; k < 4 && k < wr_log.size(); k++) begin
            check_eq("t1_wr_cycle", wr_log[k], t0 + 2 + 16 * k);
            check_eq("t1_fe", fe_log[k], k % 2);
        end
        idle(3);
        check_eq("hold_x", ox, 1);
        check_eq("hold_n", on, 3);
        check_eq("hold_wr", wr, 0);
        idle(20);

        // Fill to full during GAP, one rejected sample, then push against the pop edge.
        wr_log.delete();
        t0 = cyc;
        push(16'sd100, 1);
        idle(2);
        for (int k = 0; k < 8; k++) push(16'(200 + k), 1);
        push(16'sd300, 0);
        valid = 1'b0;
        check_eq("full_fc", fc, 8);
        check_eq("full_drop", dc, DROP_ON);
        idle(5);
        push(16'sd400, 0);
        check_eq("fc_after_pop", fc, 7);
        push(16'sd500, 1);
        valid = 1'b0;
        check_eq("fc_refill", fc, 8);
        check_eq("drop_second", dc, 2 * DROP_ON);
        wait_drain(300);
        check_eq("t2_pop_cycle", (wr_log.size() > 1) ? wr_log[1] : -1, t0 + 18);
        idle(20);

        // Reset while in GAP with three samples queued.
        push(16'sd11, 1); push(16'sd12, 1); push(16'sd13, 1); push(16'sd14, 1);
        check_eq("t3_fc_before", fc, 3);
        do_reset();
        check_zero_outputs("midreset");
        idle(20);
        push(16'sd21, 1);
        wait_drain(20);
        check_eq("t3_restart_n", on, 0);
        idle(20);

        // Frame-end marking with N=0, N=1, then N shrinking from 4 to 2 at phase 3.
        fe_log.delete();
        nlen = W'(0);
        push(16'sd31, 1); push(16'sd32, 1);
        wait_drain(60); idle(20);
        nlen = W'(1);
        push(16'sd33, 1); push(16'sd34, 1);
        wait_drain(60); idle(20);
        nlen = W'(4);
        push(16'sd35, 1); push(16'sd36, 1); push(16'sd37, 1);
        wait_drain(80); idle(20);
        nlen = W'(2);
        push(16'sd38, 1); push(16'sd39, 1); push(-16'sd40, 1);
        wait_drain(80); idle(20);
        check_eq("t4_count", fe_log.size(), 10);
        for (int k = 0; k < 10 && k < fe_log.size(); k++) check_eq("t4_fe", fe_log[k], t4_exp[k]);

        // WIDTH=4 instance: 18 samples paced at the gap, index wraps 15 -> 0.
        log4.delete();
        for (int k = 0; k < 18; k++) begin
            valid4 = 1'b1;
            x4     = W4'(k * 5);
            check_eq("ready4", ready4, 1);
            exp4_q.push_back(W4'(k * 5));
            tick();
            valid4 = 1'b0;
            for (int j = 0; j < GAP4 - 1; j++) tick();
        end
        for (int i = 0; i < 40 && exp4_q.size() != 0; i++) tick();
        idle(10);
        check_eq("w4_drain", exp4_q.size(), 0);
        check_eq("w4_count", log4.size(), 18);
        for (int k = 1; k < log4.size(); k++) check_eq("w4_spacing", log4[k] - log4[k-1], GAP4);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
